// File: rtl/mem_interleaved_responder.sv
// Purpose: on-chip line store answering interleaved memory requests; reads return in grant order.
// Latency: read grant at edge N -> response valid after edge N+RD_LAT; writes land at the grant edge and return nothing.
// Backpressure: reads are granted only while outstanding < RESP_DEPTH; writes are always granted.
//
// Ports:
//   clk, rst_n                  - single clock, asynchronous active-low reset
//   mem_interleaved_req         - {valid, isWrite, addr[63:0], data[511:0]}
//   mem_interleaved_req_grant   - request accepted this cycle (combinational)
//   mem_interleaved_resp        - {valid, data[511:0]}; valid while the response FIFO is non-empty
//   mem_interleaved_resp_grant  - initiator consumes the head response
// Optional: define MEM_INTERLEAVED_RESPONDER_STATS_EN to add stat_rd_count,
// stat_wr_count and stat_stall_count (32-bit wrapping counters).
module mem_interleaved_responder #(
  parameter int LINE_AW    = 10,
  parameter int RD_LAT     = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [577:0] mem_interleaved_req,
  output logic         mem_interleaved_req_grant,
  output logic [512:0] mem_interleaved_resp,
  input  logic         mem_interleaved_resp_grant
`ifdef MEM_INTERLEAVED_RESPONDER_STATS_EN
  ,
  output logic [31:0]  stat_rd_count,
  output logic [31:0]  stat_wr_count,
  output logic [31:0]  stat_stall_count
`endif
);

  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;

  // Request fields
  logic               req_vld;
  logic               req_is_wr;
  logic [63:0]        req_addr;
  logic [511:0]       req_dat;
  logic [LINE_AW-1:0] line_idx;
  logic               unused_addr_bits;

  assign {req_vld, req_is_wr, req_addr, req_dat} = mem_interleaved_req;
  assign line_idx = req_addr[6 +: LINE_AW];
  // Byte offset and bits above the line index are don't-care: lines wrap.
  assign unused_addr_bits = ^{req_addr[63:6+LINE_AW], req_addr[5:0]};

  // Grant logic: credits come only from registered state, so a pop in this
  // cycle cannot free a slot for a read in the same cycle.
  logic [CW-1:0] outstanding;
  logic          rd_grant;
  logic          wr_grant;

  assign rd_grant = req_vld && !req_is_wr && (outstanding < CW'(RESP_DEPTH));
  assign wr_grant = req_vld && req_is_wr;
  assign mem_interleaved_req_grant = rd_grant | wr_grant;

  // Line store and read pipeline. Stage 0 captures the store at the grant
  // edge; a read therefore sees all writes granted in earlier cycles.
  logic [511:0]      store [0:(1<<LINE_AW)-1];
  logic [511:0]      pipe_dat [0:RD_LAT-1];
  logic [RD_LAT-1:0] pipe_vld;

  always_ff @(posedge clk) begin
    if (wr_grant) store[line_idx] <= req_dat;
    if (rd_grant) pipe_dat[0] <= store[line_idx];
    for (int k = 1; k < RD_LAT; k++) pipe_dat[k] <= pipe_dat[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= rd_grant;
      for (int k = 1; k < RD_LAT; k++) pipe_vld[k] <= pipe_vld[k-1];
    end
  end

  // Response FIFO
  logic [511:0]  fifo_mem [0:RESP_DEPTH-1];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;

  assign push       = pipe_vld[RD_LAT-1];
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CW'(RESP_DEPTH));
  assign pop        = !fifo_empty && mem_interleaved_resp_grant;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= pipe_dat[RD_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
    end else begin
      // Depth is a power of two, so pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt    <= fifo_cnt + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(rd_grant) - CW'(pop);
    end
  end

  // Data is forced to zero when empty so the output is clean out of reset.
  assign mem_interleaved_resp = {!fifo_empty, fifo_empty ? 512'd0 : fifo_mem[rd_ptr]};

  // Credits guarantee a pipeline entry never meets a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (outstanding <= CW'(RESP_DEPTH)) && (fifo_cnt <= outstanding));

`ifdef MEM_INTERLEAVED_RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_count    <= '0;
      stat_wr_count    <= '0;
      stat_stall_count <= '0;
    end else begin
      if (rd_grant) stat_rd_count <= stat_rd_count + 32'd1;
      if (wr_grant) stat_wr_count <= stat_wr_count + 32'd1;
      if (req_vld && !req_is_wr && !rd_grant) stat_stall_count <= stat_stall_count + 32'd1;
    end
  end
`endif

endmodule
